// File: rtl/ftoi.sv
`timescale 1ns/1ps
// ftoi: IEEE-754 single to signed 32-bit integer, round-to-nearest-even, saturating with ovf flag.
// Latency: two registered stages, one result per cycle when ready_out is held high.
// Backpressure: valid/ready; each stage advances only when it is empty or its successor advances.
module ftoi #(
  parameter int NSTAGE = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] y,
  output logic        ovf,
  output logic        valid_out,
  input  logic        ready_out
);

  // Only the two-stage arrangement is implemented; any other depth is a configuration error.
  if (NSTAGE != 2) begin : g_nstage_check
    $error("ftoi: NSTAGE must be 2");
  end

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // zero or denormal, both convert to exactly 0
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // Stage-1 registers: decoded operand
  logic        r_v1;
  logic        r_s1;
  cls_t        r_cls1;
  logic [7:0]  r_e1;
  logic [23:0] r_ma1;

  // Stage-2 registers: final result
  logic        r_v2;
  logic [31:0] r_y;
  logic        r_ovf;

  // Handshake and datapath wires
  logic        w_en1;
  logic        w_en2;
  cls_t        w_cls;
  logic [7:0]  w_rsh;
  logic [7:0]  w_lsh;
  logic [47:0] w_ext;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rnd;
  logic [31:0] w_mag;
  logic [31:0] w_sint;
  logic [31:0] w_y;
  logic        w_ovf;

  assign w_en2    = ~r_v2 | ready_out;
  assign w_en1    = ~r_v1 | w_en2;
  assign ready_in = w_en1;

  assign y         = r_y;
  assign ovf       = r_ovf;
  assign valid_out = r_v2;

  // Classify the incoming operand from its exponent and mantissa fields
  always_comb begin
    w_cls = CLS_NORM;
    if (x[30:23] == 8'd0) begin
      w_cls = CLS_ZERO;
    end else if (x[30:23] == 8'hFF) begin
      w_cls = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

  // Stage 1: capture sign, class, exponent and mantissa with hidden bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1   <= 1'b0;
      r_s1   <= 1'b0;
      r_cls1 <= CLS_ZERO;
      r_e1   <= 8'd0;
      r_ma1  <= 24'd0;
    end else if (w_en1) begin
      r_v1 <= valid_in;
      if (valid_in) begin
        r_s1   <= x[31];
        r_cls1 <= w_cls;
        r_e1   <= x[30:23];
        r_ma1  <= {1'b1, x[22:0]};
      end
    end
  end

  // Exponent 150 puts the mantissa LSB at weight 1: above it shift left, below it shift right.
  // The right shift runs through a 48-bit window so the guard bit lands at [23] and
  // everything shifted further out is still visible for the sticky OR.
  assign w_rsh    = 8'd150 - r_e1;
  assign w_lsh    = r_e1 - 8'd150;
  assign w_ext    = {r_ma1, 24'd0} >> w_rsh;
  assign w_guard  = w_ext[23];
  assign w_sticky = |w_ext[22:0];
  assign w_rnd    = w_guard & (w_sticky | w_ext[24]);
  // Exponent is capped at 157 on this path, so the rounded magnitude stays below 2^31.
  assign w_mag    = (r_e1 >= 8'd150) ? ({8'd0, r_ma1} << w_lsh)
                                     : ({8'd0, w_ext[47:24]} + {31'd0, w_rnd});
  assign w_sint   = r_s1 ? (~w_mag + 32'd1) : w_mag;

  // Select the stage-2 result: special classes, small/huge magnitudes, or the rounded integer
  always_comb begin
    w_y   = 32'd0;
    w_ovf = 1'b0;
    case (r_cls1)
      CLS_ZERO: begin
        w_y   = 32'd0;
        w_ovf = 1'b0;
      end
      CLS_NAN: begin
        w_y   = 32'h7FFF_FFFF;
        w_ovf = 1'b1;
      end
      CLS_INF: begin
        w_y   = r_s1 ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_ovf = 1'b1;
      end
      default: begin
        if (r_e1 <= 8'd125) begin
          // |x| < 0.5 always rounds to zero
          w_y   = 32'd0;
          w_ovf = 1'b0;
        end else if (r_e1 >= 8'd158) begin
          if (!r_s1) begin
            w_y   = 32'h7FFF_FFFF;
            w_ovf = 1'b1;
          end else begin
            // -2^31 is representable exactly; anything more negative saturates
            w_y   = 32'h8000_0000;
            w_ovf = ~((r_e1 == 8'd158) && (r_ma1[22:0] == 23'd0));
          end
        end else begin
          w_y   = w_sint;
          w_ovf = 1'b0;
        end
      end
    endcase
  end

  // Stage 2: register the result; hold it while downstream stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2  <= 1'b0;
      r_y   <= 32'd0;
      r_ovf <= 1'b0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_y   <= w_y;
        r_ovf <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_ftoi.sv
`timescale 1ns/1ps
// Directed testbench for ftoi: rounding, saturation, zeros, back-pressure and reset behaviour.
module tb_ftoi;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] x = 32'd0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] y;
  logic        ovf;
  logic        valid_out;
  logic        ready_out = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  ftoi #(.NSTAGE(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .y         (y),
    .ovf       (ovf),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Push one operand into an idle pipe and return the delivered result and the
  // number of rising edges from acceptance to delivery (-1 if nothing came out).
  task automatic run_one(input logic [31:0] v, output logic [31:0] ry,
                         output logic rovf, output int lat);
    @(negedge clk);
    x = v;
    valid_in = 1'b1;
    ready_out = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    ry = 32'd0;
    rovf = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid_out) begin
        ry = y;
        rovf = ovf;
        lat = k;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    n_vec++;
    if (y !== 32'd0) begin n_err++; $display("FAIL reset_y: got %h expected 00000000", y); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_vec++;
    if (ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_rounding;
    logic [31:0] vin  [6] = '{32'h3F000000, 32'h3F400000, 32'h3FC00000,
                              32'h40200000, 32'hC0200000, 32'h4EFFFFFF};
    logic [31:0] vexp [6] = '{32'h00000000, 32'h00000001, 32'h00000002,
                              32'h00000002, 32'hFFFFFFFE, 32'h7FFFFF80};
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(vin[i], ry, rovf, lat);
      n_vec++;
      if (ry !== vexp[i]) begin n_err++; $display("FAIL round_y[%h]: got %h expected %h", vin[i], ry, vexp[i]); end
      n_vec++;
      if (rovf !== 1'b0) begin n_err++; $display("FAIL round_ovf[%h]: got %b expected 0", vin[i], rovf); end
      n_vec++;
      if (lat !== 2) begin n_err++; $display("FAIL round_latency[%h]: got %0d expected 2", vin[i], lat); end
    end
  endtask

  task automatic test_normal;
    // -1.0, just under 0.5, just under 1.0, 2^23+1, 1.75, -3.5 (tie to even -> -4)
    logic [31:0] vin  [6] = '{32'hBF800000, 32'h3EFFFFFF, 32'h3F7FFFFF,
                              32'h4B000001, 32'h3FE00000, 32'hC0600000};
    logic [31:0] vexp [6] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001,
                              32'h00800001, 32'h00000002, 32'hFFFFFFFC};
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(vin[i], ry, rovf, lat);
      n_vec++;
      if ({rovf, ry} !== {1'b0, vexp[i]}) begin
        n_err++;
        $display("FAIL normal[%h]: got y=%h ovf=%b expected y=%h ovf=0", vin[i], ry, rovf, vexp[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] vin  [6] = '{32'h4F000000, 32'hCF000000, 32'hCF000001,
                              32'h7F800000, 32'hFF800000, 32'h7FC00000};
    logic [31:0] vexp [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                              32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic        oexp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(vin[i], ry, rovf, lat);
      n_vec++;
      if (ry !== vexp[i]) begin n_err++; $display("FAIL sat_y[%h]: got %h expected %h", vin[i], ry, vexp[i]); end
      n_vec++;
      if (rovf !== oexp[i]) begin n_err++; $display("FAIL sat_ovf[%h]: got %b expected %b", vin[i], rovf, oexp[i]); end
    end
  endtask

  task automatic test_zero_denorm;
    logic [31:0] vin [4] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF};
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_one(vin[i], ry, rovf, lat);
      n_vec++;
      if ({rovf, ry} !== 33'd0) begin
        n_err++;
        $display("FAIL zero[%h]: got y=%h ovf=%b expected y=00000000 ovf=0", vin[i], ry, rovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] fin [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic        exp_rdy [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] outs [$];
    int          idx = 0;
    logic        s_acc;
    logic        s_del;
    logic [31:0] s_y;
    @(posedge clk);
    #1;
    for (int c = 0; c < 30 && outs.size() < 8; c++) begin
      ready_out = !(c >= 4 && c <= 6);
      valid_in = (idx < 8);
      x = (idx < 8) ? fin[idx] : 32'd0;
      @(negedge clk);
      if (valid_in && c < 11) begin
        n_vec++;
        if (ready_in !== exp_rdy[c]) begin n_err++; $display("FAIL bp_ready_in[c%0d]: got %b expected %b", c, ready_in, exp_rdy[c]); end
      end
      if (c >= 4 && c <= 6) begin
        n_vec++;
        if ({valid_out, y} !== {1'b1, 32'd3}) begin
          n_err++;
          $display("FAIL bp_hold[c%0d]: got valid_out=%b y=%h expected 1/00000003", c, valid_out, y);
        end
      end
      s_acc = valid_in && ready_in;
      s_del = valid_out && ready_out;
      s_y = y;
      @(posedge clk);
      #1;
      if (s_acc) idx++;
      if (s_del) outs.push_back(s_y);
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    n_vec++;
    if (outs.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", outs.size()); end
    for (int i = 0; i < 8 && i < outs.size(); i++) begin
      n_vec++;
      if (outs[i] !== 32'(i + 1)) begin n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", i, outs[i], 32'(i + 1)); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (valid_out !== 1'b0) begin n_err++; $display("FAIL bp_extra[c%0d]: got valid_out=%b expected 0", c, valid_out); end
    end
  endtask

  task automatic test_reset_midop;
    int          nout = 0;
    logic [31:0] last_y = 32'd0;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    valid_in = 1'b1;
    x = 32'h40A00000;
    @(posedge clk);
    #1 x = 32'h40C00000;
    @(posedge clk);
    #1 valid_in = 1'b0;
    n_vec++;
    if (valid_out !== 1'b1 || ready_in !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_full: got valid_out=%b ready_in=%b expected 1/0", valid_out, ready_in);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({valid_out, y, ovf} !== 34'd0) begin
      n_err++;
      $display("FAIL midrst_async: got valid_out=%b y=%h ovf=%b expected 0/00000000/0", valid_out, y, ovf);
    end
    n_vec++;
    if (ready_in !== 1'b1) begin n_err++; $display("FAIL midrst_ready_in: got %b expected 1", ready_in); end
    @(posedge clk);
    @(negedge clk);
    x = 32'h40400000;
    valid_in = 1'b1;
    ready_out = 1'b1;
    rstn = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_out) begin
        nout++;
        last_y = y;
      end
    end
    n_vec++;
    if (nout !== 1) begin n_err++; $display("FAIL midrst_count: got %0d results expected 1", nout); end
    n_vec++;
    if (last_y !== 32'd3) begin n_err++; $display("FAIL midrst_first: got %h expected 00000003", last_y); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_normal();
    test_saturation();
    test_zero_denorm();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
